// File: rtl/eb_rr_merge.sv
// N-to-1 packet-aware round-robin merge onto one registered elastic output stage.
// A source that starts a multi-beat packet keeps the grant until its last beat is accepted.
module eb_rr_merge #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     t_req,
    output logic [N-1:0]     t_ack,
    input  logic [N*W-1:0]   t_data,
    input  logic [N-1:0]     t_last,
    output logic             i_0_req,
    input  logic             i_0_ack,
    output logic [W-1:0]     i_0_data,
    output logic [IDW-1:0]   i_0_id,
    output logic             i_0_last
);

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_lsrc;
    logic           r_locked;

    logic           r_req;
    logic [W-1:0]   r_data;
    logic [IDW-1:0] r_id;
    logic           r_last;

    logic           w_load;
    logic           w_granted;
    logic           w_fire;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_next_ptr;

    // (base + off) modulo N, given base < N and off < N.
    function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IDW'(sum);
    endfunction

    assign w_load = !r_req || i_0_ack;
    assign w_fire = w_load && w_granted;

    always_comb begin
        w_granted = 1'b0;
        w_grant   = '0;
        if (r_locked) begin
            if (t_req[r_lsrc]) begin
                w_granted = 1'b1;
                w_grant   = r_lsrc;
            end
        end else begin
            // NOTE: scanning from the far end and overwriting lets the nearest requester win without a break.
            for (int off = N - 1; off >= 0; off--) begin
                if (t_req[wrap_idx(int'(r_ptr), off)]) begin
                    w_granted = 1'b1;
                    w_grant   = wrap_idx(int'(r_ptr), off);
                end
            end
        end
    end

    assign w_next_ptr = (int'(w_grant) == N - 1) ? '0 : w_grant + 1'b1;

    always_comb begin
        t_ack = '0;
        if (w_fire) begin
            t_ack[w_grant] = 1'b1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req    <= 1'b0;
            r_data   <= '0;
            r_id     <= '0;
            r_last   <= 1'b0;
            r_ptr    <= '0;
            r_locked <= 1'b0;
            r_lsrc   <= '0;
        end else begin
            if (w_load) begin
                r_req <= w_granted;
                if (w_granted) begin
                    r_data <= t_data[int'(w_grant)*W +: W];
                    r_id   <= w_grant;
                    r_last <= t_last[w_grant];
                end
            end
            if (w_fire) begin
                if (t_last[w_grant]) begin
                    r_locked <= 1'b0;
                    r_ptr    <= w_next_ptr;
                end else begin
                    r_locked <= 1'b1;
                    r_lsrc   <= w_grant;
                end
            end
        end
    end

    assign i_0_req  = r_req;
    assign i_0_data = r_data;
    assign i_0_id   = r_id;
    assign i_0_last = r_last;

endmodule

// File: tb/tb_eb_rr_merge.sv
// Bench for eb_rr_merge: queue-fed sources, cycle-level reference model, directed scenarios,
// plus a three-source instance for the non-power-of-two wrap.
module tb_eb_rr_merge;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     t_req;
    logic [N-1:0]     t_ack;
    logic [N*W-1:0]   t_data;
    logic [N-1:0]     t_last;
    logic             i_0_req;
    logic             i_0_ack;
    logic [W-1:0]     i_0_data;
    logic [IDW-1:0]   i_0_id;
    logic             i_0_last;

    logic [2:0]       t3_ack;
    logic             o3_req;
    logic [W-1:0]     o3_data;
    logic [1:0]       o3_id;
    logic             o3_last;

    always #5 clk = ~clk;

    eb_rr_merge #(.N(N), .W(W), .IDW(IDW)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .t_req    (t_req),
        .t_ack    (t_ack),
        .t_data   (t_data),
        .t_last   (t_last),
        .i_0_req  (i_0_req),
        .i_0_ack  (i_0_ack),
        .i_0_data (i_0_data),
        .i_0_id   (i_0_id),
        .i_0_last (i_0_last)
    );

    // Three always-requesting single-beat sources; source k carries data value k.
    eb_rr_merge #(.N(3), .W(W), .IDW(2)) u_dut3 (
        .clk      (clk),
        .reset    (reset),
        .t_req    (3'b111),
        .t_ack    (t3_ack),
        .t_data   ({32'd2, 32'd1, 32'd0}),
        .t_last   (3'b111),
        .i_0_req  (o3_req),
        .i_0_ack  (1'b1),
        .i_0_data (o3_data),
        .i_0_id   (o3_id),
        .i_0_last (o3_last)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    beat_t      src_q [N][$];
    logic [N-1:0] mute     = '0;
    logic [N-1:0] ack_seen = '0;
    int         obs[$];
    int         exp_q[$];
    int         ids3[$];
    bit         log3 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_obs(input string name);
        check({name, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check(name, 64'(obs[i]), 64'(exp_q[i]));
        end
    endtask

    function automatic logic [W-1:0] mk(input int k, input int pkt, input int beat);
        return {8'(k), 8'(pkt), 8'(beat), 8'hA5};
    endfunction

    task automatic push(input int k, input int pkt, input int nb);
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            bt.data = mk(k, pkt, b);
            bt.last = (b == nb - 1);
            src_q[k].push_back(bt);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && !mute[k]) begin
                t_req[k]         = 1'b1;
                t_data[k*W +: W] = src_q[k][0].data;
                t_last[k]        = src_q[k][0].last;
            end else begin
                t_req[k]         = 1'b0;
                t_data[k*W +: W] = '0;
                t_last[k]        = 1'b0;
            end
        end
    endtask

    // Advance one clock; retire beats acknowledged in the cycle just ended, then present the next.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (ack_seen[k] === 1'b1 && src_q[k].size() > 0) begin
                void'(src_q[k].pop_front());
            end
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) src_q[k].delete();
        mute    = '0;
        reset   = 1'b1;
        i_0_ack = 1'b1;
        drive();
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    // Reference model: output slot plus arbitration state, advanced from the transfer rules.
    int           m_ptr = 0, m_lsrc = 0, m_id = 0;
    bit           m_locked = 0, m_vld = 0, m_last = 0, model_on = 0;
    logic [W-1:0] m_data = '0;
    int           n_ptr, n_lsrc, n_id;
    bit           n_locked, n_vld, n_last;
    logic [W-1:0] n_data;

    always @(negedge clk) begin
        bit           ld;
        bit           fnd;
        int           g;
        logic [N-1:0] ea;
        ld  = !m_vld || (i_0_ack === 1'b1);
        fnd = 1'b0;
        g   = 0;
        if (m_locked) begin
            if (t_req[m_lsrc] === 1'b1) begin
                fnd = 1'b1;
                g   = m_lsrc;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!fnd && t_req[(m_ptr + i) % N] === 1'b1) begin
                    fnd = 1'b1;
                    g   = (m_ptr + i) % N;
                end
            end
        end
        ea = '0;
        if (ld && fnd) ea[g] = 1'b1;

        if (model_on) begin
            check("model_t_ack", 64'(t_ack), 64'(ea));
            check("model_i_0_req", 64'(i_0_req), 64'(m_vld));
            if (m_vld) begin
                check("model_i_0_data", 64'(i_0_data), 64'(m_data));
                check("model_i_0_id", 64'(i_0_id), 64'(m_id));
                check("model_i_0_last", 64'(i_0_last), 64'(m_last));
            end
        end
        ack_seen = t_ack;
        if (model_on && !reset && i_0_req === 1'b1 && i_0_ack === 1'b1) begin
            obs.push_back(int'(i_0_id));
        end

        n_ptr = m_ptr; n_lsrc = m_lsrc; n_locked = m_locked;
        n_vld = m_vld; n_data = m_data; n_id = m_id; n_last = m_last;
        if (ld) begin
            n_vld = fnd;
            if (fnd) begin
                n_data = t_data[g*W +: W];
                n_id   = g;
                n_last = t_last[g];
            end
        end
        if (ld && fnd) begin
            if (t_last[g]) begin
                n_locked = 1'b0;
                n_ptr    = (g + 1) % N;
            end else begin
                n_locked = 1'b1;
                n_lsrc   = g;
            end
        end
    end

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            model_on = 1'b1;
            m_ptr = 0; m_lsrc = 0; m_locked = 0;
            m_vld = 0; m_data = '0; m_id = 0; m_last = 0;
        end else if (model_on) begin
            m_ptr = n_ptr; m_lsrc = n_lsrc; m_locked = n_locked;
            m_vld = n_vld; m_data = n_data; m_id = n_id; m_last = n_last;
        end
    end

    always @(negedge clk) begin
        if (log3 && o3_req === 1'b1) begin
            ids3.push_back(int'(o3_id));
            check("n3_data_matches_id", 64'(o3_data), 64'(o3_id));
            check("n3_ack_onehot", 64'($countones(t3_ack) <= 1), 64'(1));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        i_0_ack = 1'b1;
        t_req   = '0;
        t_data  = '0;
        t_last  = '0;

        do_reset();
        log3 = 1'b1;
        check("reset_i_0_req", 64'(i_0_req), 64'(0));
        check("reset_i_0_data", 64'(i_0_data), 64'(0));
        check("reset_i_0_id", 64'(i_0_id), 64'(0));
        check("reset_i_0_last", 64'(i_0_last), 64'(0));
        check("reset_t_ack", 64'(t_ack), 64'(0));

        // Single-beat round robin across all sources.
        obs.delete();
        push(0, 0, 1); push(1, 0, 1); push(2, 0, 1); push(3, 0, 1); push(0, 1, 1);
        drive();
        @(negedge clk);
        check("t1_first_ack", 64'(t_ack), 64'(4'b0001));
        check("t1_req_before_latency", 64'(i_0_req), 64'(0));
        cycle();
        @(negedge clk);
        check("t1_req_after_latency", 64'(i_0_req), 64'(1));
        check("t1_first_id", 64'(i_0_id), 64'(0));
        run(8);
        exp_q = '{0, 1, 2, 3, 0};
        check_obs("t1_ids");
        log3 = 1'b0;

        // Three-source wrap never yields index 3.
        check("n3_count", 64'(ids3.size() >= 8), 64'(1));
        exp_q = '{0, 1, 2, 0, 1, 2, 0, 1};
        for (int i = 0; i < 8 && i < ids3.size(); i++) begin
            check("n3_ids", 64'(ids3[i]), 64'(exp_q[i]));
        end

        // Multi-beat packet from source 2 is not interleaved.
        obs.delete();
        push(1, 2, 1);
        cycle();
        push(2, 2, 3); push(0, 2, 1); push(1, 3, 1); push(3, 2, 1);
        run(10);
        exp_q = '{1, 2, 2, 2, 3, 0, 1};
        check_obs("t2_ids");

        // Backpressure freezes everything; release drains and accepts in one cycle.
        obs.delete();
        i_0_ack = 1'b0;
        push(0, 4, 1); push(0, 5, 1); push(2, 4, 1);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_ack", 64'(t_ack), 64'(0));
            check("t3_hold_req", 64'(i_0_req), 64'(1));
            check("t3_hold_data", 64'(i_0_data), 64'(mk(2, 4, 0)));
            cycle();
        end
        i_0_ack = 1'b1;
        @(negedge clk);
        check("t3_release_ack", 64'(t_ack), 64'(4'b0001));
        check("t3_release_id", 64'(i_0_id), 64'(2));
        run(6);
        exp_q = '{2, 0, 0};
        check_obs("t3_ids");

        // Locked source 1 pauses mid-packet; source 0 must wait through the bubble.
        do_reset();
        obs.delete();
        push(1, 6, 3);
        cycle();
        mute[1] = 1'b1;
        push(0, 6, 1);
        cycle();
        @(negedge clk);
        check("t4_starve_ack_a", 64'(t_ack), 64'(0));
        cycle();
        mute[1] = 1'b0;
        @(negedge clk);
        check("t4_starve_ack_b", 64'(t_ack), 64'(0));
        check("t4_bubble", 64'(i_0_req), 64'(0));
        run(8);
        exp_q = '{1, 1, 1, 0};
        check_obs("t4_ids");

        // Reset after beat 1 of a 4-beat packet from source 3 drops the lock.
        do_reset();
        obs.delete();
        push(3, 7, 4);
        cycle();
        reset   = 1'b1;
        i_0_ack = 1'b0;
        push(0, 7, 1);
        cycle();
        reset   = 1'b0;
        i_0_ack = 1'b1;
        @(negedge clk);
        check("t5_req_after_reset", 64'(i_0_req), 64'(0));
        check("t5_first_grant", 64'(t_ack), 64'(4'b0001));
        run(10);
        exp_q = '{0, 3, 3, 3};
        check_obs("t5_ids");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
